// File: rtl/nim_dac_sequencer.sv
// NIM+ threshold DAC sequencer.
// On start, snapshots all channel thresholds and shifts N_CH data frames
// followed by one update-control frame out of a 3-wire serial DAC port.
//
// Handshake: start is a single-cycle request honoured only in IDLE; busy is
// high while frames are in flight (SETUP/SHIFT/GAP); done pulses for exactly
// one cycle when all N_CH+1 frames are out. Aborted transactions never pulse done.
module nim_dac_sequencer #(
  parameter int          N_CH        = 8,
  parameter int          CLK_DIV     = 4,
  parameter int          GAP_CYCLES  = 4,
  parameter logic [15:0] UPDATE_WORD = 16'hA000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_CH*12-1:0] thresholds,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               DAC_SER_CLK,
  output logic               DAC_NSYNC,
  output logic               DAC_DIN,
  output logic [7:0]         frame_cnt,
  output logic [2:0]         dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [N_CH*12-1:0] snap_q, snap_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic [7:0]         div_q, div_d;     // half-period / setup / gap counter
  logic [3:0]         bit_q, bit_d;     // index of bit currently on DIN
  logic               phase_q, phase_d; // 0: SER_CLK high half, 1: low half

  logic [11:0] ch_code;
  logic [15:0] frame_word;
  logic        div_last;
  logic        gap_last;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      snap_q      <= '0;
      frame_cnt_q <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      frame_cnt_q <= frame_cnt_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      phase_q     <= phase_d;
    end
  end

  // Build the 16-bit word for the frame currently being sent.
  always_comb begin
    ch_code = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (frame_cnt_q == 8'(k)) ch_code = snap_q[12*k +: 12];
    end
    if (int'(frame_cnt_q) < N_CH) frame_word = {1'b0, frame_cnt_q[2:0], ch_code};
    else                          frame_word = UPDATE_WORD;
  end

  assign div_last = (div_q == 8'(CLK_DIV - 1));
  assign gap_last = (div_q == 8'(GAP_CYCLES - 1));

  // Next-state logic: frame timing and sequencing.
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    frame_cnt_d = frame_cnt_q;
    div_d       = div_q;
    bit_d       = bit_q;
    phase_d     = phase_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_SETUP;
          snap_d      = thresholds;
          frame_cnt_d = '0;
          div_d       = '0;
        end
      end
      ST_SETUP: begin
        if (div_last) begin
          state_d = ST_SHIFT;
          div_d   = '0;
          bit_d   = 4'd15;
          phase_d = 1'b0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_SHIFT: begin
        if (div_last) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else if (bit_q == 4'd0) begin
            state_d     = ST_GAP;
            phase_d     = 1'b0;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            bit_d   = bit_q - 4'd1;
            phase_d = 1'b0;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (gap_last) begin
          div_d = '0;
          if (int'(frame_cnt_q) < N_CH + 1) state_d = ST_SETUP;
          else                              state_d = ST_DONE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    busy        = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_GAP);
    done        = (state_q == ST_DONE);
    DAC_NSYNC   = !((state_q == ST_SETUP) || (state_q == ST_SHIFT));
    DAC_SER_CLK = !((state_q == ST_SHIFT) && phase_q);
    DAC_DIN     = 1'b0;
    if (state_q == ST_SETUP)      DAC_DIN = frame_word[15];
    else if (state_q == ST_SHIFT) DAC_DIN = frame_word[bit_q];
  end

  assign frame_cnt   = frame_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_nim_dac_sequencer.sv
// Randomized bench for nim_dac_sequencer: two instances (CLK_DIV=2 and
// CLK_DIV=1), a serial-port decoder, and a frame-list reference model.
module tb_nim_dac_sequencer;

  localparam int A_NCH = 8, A_DIV = 2, A_GAP = 4;
  localparam int B_NCH = 4, B_DIV = 1, B_GAP = 3;
  localparam int A_LAT = (A_NCH + 1) * (A_DIV + 32 * A_DIV + A_GAP) + 1;
  localparam int B_LAT = (B_NCH + 1) * (B_DIV + 32 * B_DIV + B_GAP) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_a = 1'b1, rst_b = 1'b1;
  logic                 start_a = 1'b0, start_b = 1'b0;
  logic [A_NCH*12-1:0]  thr_a = '0;
  logic [B_NCH*12-1:0]  thr_b = '0;
  logic                 busy_a, done_a, sclk_a, nsync_a, din_a;
  logic                 busy_b, done_b, sclk_b, nsync_b, din_b;
  logic [7:0]           fcnt_a, fcnt_b;
  logic [2:0]           dbg_a, dbg_b;

  nim_dac_sequencer #(.N_CH(A_NCH), .CLK_DIV(A_DIV), .GAP_CYCLES(A_GAP)) dut_a (
    .clk(clk), .reset(rst_a), .thresholds(thr_a), .start(start_a),
    .busy(busy_a), .done(done_a), .DAC_SER_CLK(sclk_a), .DAC_NSYNC(nsync_a),
    .DAC_DIN(din_a), .frame_cnt(fcnt_a), .dbg_state_o(dbg_a));

  nim_dac_sequencer #(.N_CH(B_NCH), .CLK_DIV(B_DIV), .GAP_CYCLES(B_GAP)) dut_b (
    .clk(clk), .reset(rst_b), .thresholds(thr_b), .start(start_b),
    .busy(busy_b), .done(done_b), .DAC_SER_CLK(sclk_b), .DAC_NSYNC(nsync_b),
    .DAC_DIN(din_b), .frame_cnt(fcnt_b), .dbg_state_o(dbg_b));

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q_a[$];
  logic [15:0] exp_q_b[$];
  logic [15:0] got_a[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: N data frames {0, ch, code} in channel order, then the update word.
  task automatic push_model(input int id, input logic [95:0] thr, input int nch);
    logic [15:0] w;
    for (int k = 0; k < nch; k++) begin
      w = {1'b0, 3'(k), thr[12*k +: 12]};
      if (id == 0) exp_q_a.push_back(w); else exp_q_b.push_back(w);
    end
    if (id == 0) exp_q_a.push_back(16'hA000); else exp_q_b.push_back(16'hA000);
  endtask

  // ---------------- serial port decoder ----------------
  logic        prev_ser[2]   = '{1'b1, 1'b1};
  logic        prev_nsync[2] = '{1'b1, 1'b1};
  logic        prev_din[2]   = '{1'b0, 1'b0};
  logic        abort_ok[2]   = '{1'b0, 1'b0};
  logic [15:0] shreg[2]      = '{16'h0, 16'h0};
  int          nbits[2]      = '{0, 0};
  int          low_len[2]    = '{0, 0};
  int          cyc[2]        = '{0, 0};
  int          last_fall[2]  = '{0, 0};
  int          done_cnt[2]   = '{0, 0};

  task automatic mon_step(input int id, input logic nsync, input logic ser,
                          input logic din, input logic dn, input int div);
    cyc[id]++;
    if (dn) done_cnt[id]++;
    if (!nsync) begin
      low_len[id]++;
      if (prev_ser[id] && !ser) begin
        check("din_stable_at_fall", 32'(din), 32'(prev_din[id]));
        if (nbits[id] > 0) check("sclk_period", cyc[id] - last_fall[id], 2 * div);
        last_fall[id] = cyc[id];
        shreg[id] = {shreg[id][14:0], din};
        nbits[id]++;
      end
    end else if (!prev_nsync[id]) begin
      if (abort_ok[id]) begin
        abort_ok[id] = 1'b0;
      end else begin
        check("frame_bits", nbits[id], 16);
        check("frame_nsync_low_len", low_len[id], 33 * div);
        if (id == 0) begin
          check("exp_q_a_nonempty", 32'(exp_q_a.size() != 0), 32'd1);
          if (exp_q_a.size() != 0) check("frame_word_a", 32'(shreg[id]), 32'(exp_q_a.pop_front()));
          got_a.push_back(shreg[id]);
        end else begin
          check("exp_q_b_nonempty", 32'(exp_q_b.size() != 0), 32'd1);
          if (exp_q_b.size() != 0) check("frame_word_b", 32'(shreg[id]), 32'(exp_q_b.pop_front()));
        end
      end
      nbits[id]   = 0;
      low_len[id] = 0;
    end
    prev_ser[id]   = ser;
    prev_nsync[id] = nsync;
    prev_din[id]   = din;
  endtask

  always @(negedge clk) begin
    mon_step(0, nsync_a, sclk_a, din_a, done_a, A_DIV);
    mon_step(1, nsync_b, sclk_b, din_b, done_b, B_DIV);
  end

  // ---------------- driver tasks ----------------
  // Returns at negedge 1, i.e. the cycle right after start is sampled.
  task automatic pulse_start(input int id);
    @(negedge clk);
    if (id == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    if (id == 0) start_a = 1'b0; else start_b = 1'b0;
  endtask

  // Counts negedges from n0 until done is seen (bounded).
  task automatic wait_done(input int id, input int n0, input int budget, output int n);
    n = n0;
    while (!(id == 0 ? done_a : done_b) && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic rand_thr_a();
    thr_a = {$urandom, $urandom, $urandom};
  endtask

  // ---------------- main sequence ----------------
  int          n;
  int          dc;
  logic [95:0] snap;

  initial begin
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    // Reset state
    check("rst_nsync", 32'(nsync_a), 32'd1);
    check("rst_sclk", 32'(sclk_a), 32'd1);
    check("rst_din", 32'(din_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_frame_cnt", 32'(fcnt_a), 32'd0);

    // Directed run: ch0=123, ch7=FFF
    rand_thr_a();
    thr_a[11:0]  = 12'h123;
    thr_a[95:84] = 12'hFFF;
    push_model(0, thr_a, A_NCH);
    got_a.delete();
    dc = done_cnt[0];
    pulse_start(0);
    check("busy_after_start", 32'(busy_a), 32'd1);
    wait_done(0, 1, 2000, n);
    check("done_latency", n, A_LAT);
    @(negedge clk);
    check("frame_cnt_end", 32'(fcnt_a), 32'd9);
    check("busy_after_done", 32'(busy_a), 32'd0);
    check("done_single_cycle", 32'(done_a), 32'd0);
    check("done_count", done_cnt[0], dc + 1);
    check("got_frames", 32'(got_a.size()), 32'd9);
    if (got_a.size() == 9) begin
      check("frame0", 32'(got_a[0]), 32'h0123);
      check("frame7", 32'(got_a[7]), 32'h7FFF);
      check("frame8", 32'(got_a[8]), 32'hA000);
    end

    // Random runs; in the first one thresholds change and start re-pulses mid-transaction
    for (int t = 0; t < 3; t++) begin
      rand_thr_a();
      snap = thr_a;
      push_model(0, snap, A_NCH);
      got_a.delete();
      dc = done_cnt[0];
      pulse_start(0);
      n = 1;
      if (t == 0) begin
        repeat (100) @(negedge clk);
        rand_thr_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 102;
      end
      wait_done(0, n, 2000, n);
      check("done_latency_rand", n, A_LAT);
      repeat (3) @(negedge clk);
      check("done_count_rand", done_cnt[0], dc + 1);
      check("busy_idle_rand", 32'(busy_a), 32'd0);
      if (got_a.size() > 3) check("frame3_snapshot", 32'(got_a[3]), {16'h0, 1'b0, 3'd3, snap[47:36]});
    end

    // Reset during frame 2, bit 9: cycle 2*70 + 2 + 6*4 + 2 = 168 after start
    rand_thr_a();
    push_model(0, thr_a, A_NCH);
    dc = done_cnt[0];
    pulse_start(0);
    repeat (167) @(negedge clk);
    check("abort_at_frame2", 32'(fcnt_a), 32'd2);
    check("abort_nsync_low", 32'(nsync_a), 32'd0);
    check("abort_bit9_high_half", 32'(sclk_a), 32'd1);
    abort_ok[0] = 1'b1;
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("abort_nsync", 32'(nsync_a), 32'd1);
    check("abort_sclk", 32'(sclk_a), 32'd1);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_frame_cnt", 32'(fcnt_a), 32'd0);
    check("abort_din", 32'(din_a), 32'd0);
    exp_q_a.delete();
    repeat (700) @(negedge clk);
    check("abort_no_done", done_cnt[0], dc);
    check("abort_still_idle", 32'(busy_a), 32'd0);

    // start and reset in the same cycle
    @(negedge clk);
    start_a = 1'b1;
    rst_a   = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    rst_a   = 1'b0;
    check("start_rst_busy", 32'(busy_a), 32'd0);
    repeat (3) @(negedge clk);
    check("start_rst_busy_later", 32'(busy_a), 32'd0);
    check("start_rst_nsync", 32'(nsync_a), 32'd1);

    // start during DONE ignored, start in the following IDLE accepted
    rand_thr_a();
    push_model(0, thr_a, A_NCH);
    pulse_start(0);
    wait_done(0, 1, 2000, n);
    check("done_latency_x", n, A_LAT);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("start_in_done_ignored", 32'(busy_a), 32'd0);
    @(negedge clk);
    check("start_in_done_ignored2", 32'(busy_a), 32'd0);
    rand_thr_a();
    push_model(0, thr_a, A_NCH);
    pulse_start(0);
    wait_done(0, 1, 2000, n);
    check("done_latency_y", n, A_LAT);
    rand_thr_a();
    push_model(0, thr_a, A_NCH);
    start_a = 1'b1; // this negedge is the DONE cycle; hold into IDLE
    @(negedge clk);
    @(negedge clk);
    start_a = 1'b0;
    check("start_in_idle_accepted", 32'(busy_a), 32'd1);
    wait_done(0, 1, 2000, n);
    check("done_latency_z", n, A_LAT);

    // CLK_DIV=1 instance
    thr_b = 48'({$urandom, $urandom});
    push_model(1, 96'(thr_b), B_NCH);
    dc = done_cnt[1];
    pulse_start(1);
    wait_done(1, 1, 1000, n);
    check("b_done_latency", n, B_LAT);
    @(negedge clk);
    check("b_frame_cnt", 32'(fcnt_b), 32'(B_NCH + 1));
    repeat (3) @(negedge clk);
    check("b_done_count", done_cnt[1], dc + 1);

    repeat (5) @(negedge clk);
    check("exp_q_a_drained", 32'(exp_q_a.size()), 32'd0);
    check("exp_q_b_drained", 32'(exp_q_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
